// File: rtl/can_frame_decoder.sv
// CAN standard data frame decoder: latches a 108-bit frame, recomputes CRC-15 serially,
// checks fixed-form bits and presents the result on a valid/ready handshake.
// Optional acceptance filter enabled by defining CAN_DEC_ACCEPT_FILTER_EN.
module can_frame_decoder #(
   parameter int unsigned FRAME_BITS  = 108,
   parameter logic [14:0] CRC_POLY    = 15'h4599,
   parameter logic [10:0] FILTER_CODE = 11'h000,
   parameter logic [10:0] FILTER_MASK = 11'h000
) (
   input  logic                  i_Clock,
   input  logic                  i_Rst_n,
   input  logic                  i_Rx_DV,
   input  logic [0:FRAME_BITS-1] i_Rx_Frame,
   input  logic                  i_Frame_Ready,
   output logic                  o_Frame_Valid,
   output logic [10:0]           o_Id,
   output logic                  o_Rtr,
   output logic [3:0]            o_Dlc,
   output logic [63:0]           o_Data,
   output logic                  o_Crc_Err,
   output logic                  o_Form_Err,
   output logic                  o_Busy,
   output logic                  o_Overrun
);

   localparam logic [6:0] LastCrcBit = 7'd82;

   typedef enum logic [1:0] {StIdle, StCrcRun, StCheck, StOut} state_e;

   state_e                state_q, state_d;
   logic [0:FRAME_BITS-1] frame_q, frame_d;
   logic [14:0]           crc_q, crc_d;
   logic [6:0]            idx_q, idx_d;
   logic                  valid_q, valid_d;
   logic [10:0]           id_q, id_d;
   logic                  rtr_q, rtr_d;
   logic [3:0]            dlc_q, dlc_d;
   logic [63:0]           data_q, data_d;
   logic                  crc_err_q, crc_err_d;
   logic                  form_err_q, form_err_d;
   logic                  overrun_q, overrun_d;

   logic                  crc_fb;
   logic                  form_viol;
   logic                  accept;

   // r0 and the ACK slot are not checked
   logic unused_fields;
   assign unused_fields = ^{frame_q[14], frame_q[99]};

   assign form_viol = frame_q[0] | frame_q[13] | ~frame_q[98] | ~frame_q[100]
                    | ~(&frame_q[101:107]) | (frame_q[15:18] > 4'd8);

`ifdef CAN_DEC_ACCEPT_FILTER_EN
   assign accept = ~(|((frame_q[1:11] ^ FILTER_CODE) & FILTER_MASK));
`else
   logic unused_filter;
   assign unused_filter = ^{FILTER_CODE, FILTER_MASK};
   assign accept        = 1'b1;
`endif

   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      crc_d      = crc_q;
      idx_d      = idx_q;
      valid_d    = valid_q;
      id_d       = id_q;
      rtr_d      = rtr_q;
      dlc_d      = dlc_q;
      data_d     = data_q;
      crc_err_d  = crc_err_q;
      form_err_d = form_err_q;
      crc_fb     = 1'b0;
      // Any strobe outside IDLE is dropped, including on the handshake clock
      overrun_d  = i_Rx_DV && (state_q != StIdle);

      unique case (state_q)
         StIdle: begin
            if (i_Rx_DV) begin
               frame_d = i_Rx_Frame;
               crc_d   = '0;
               idx_d   = '0;
               state_d = StCrcRun;
            end
         end
         StCrcRun: begin
            crc_fb = frame_q[idx_q] ^ crc_q[14];
            crc_d  = {crc_q[13:0], 1'b0} ^ (crc_fb ? CRC_POLY : 15'd0);
            idx_d  = idx_q + 7'd1;
            if (idx_q == LastCrcBit) begin
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (accept) begin
               id_d       = frame_q[1:11];
               rtr_d      = frame_q[12];
               dlc_d      = frame_q[15:18];
               data_d     = frame_q[19:82];
               crc_err_d  = (crc_q != frame_q[83:97]);
               form_err_d = form_viol;
               valid_d    = 1'b1;
               state_d    = StOut;
            end else begin
               state_d = StIdle;
            end
         end
         StOut: begin
            if (i_Frame_Ready) begin
               valid_d    = 1'b0;
               crc_err_d  = 1'b0;
               form_err_d = 1'b0;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q    <= StIdle;
         frame_q    <= '0;
         crc_q      <= '0;
         idx_q      <= '0;
         valid_q    <= 1'b0;
         id_q       <= '0;
         rtr_q      <= 1'b0;
         dlc_q      <= '0;
         data_q     <= '0;
         crc_err_q  <= 1'b0;
         form_err_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         crc_q      <= crc_d;
         idx_q      <= idx_d;
         valid_q    <= valid_d;
         id_q       <= id_d;
         rtr_q      <= rtr_d;
         dlc_q      <= dlc_d;
         data_q     <= data_d;
         crc_err_q  <= crc_err_d;
         form_err_q <= form_err_d;
         overrun_q  <= overrun_d;
      end
   end

   assign o_Frame_Valid = valid_q;
   assign o_Id          = id_q;
   assign o_Rtr         = rtr_q;
   assign o_Dlc         = dlc_q;
   assign o_Data        = data_q;
   assign o_Crc_Err     = crc_err_q;
   assign o_Form_Err    = form_err_q;
   assign o_Busy        = (state_q != StIdle);
   assign o_Overrun     = overrun_q;

endmodule

// File: doc/can_frame_decoder.md
Name: can_frame_decoder

Overview:
Downstream consumer of the CAN receiver's 108-bit frame vector and its data-valid strobe. Latches each received standard data frame and extracts ID, RTR, DLC and the 64-bit data field. Recomputes CRC-15 serially and checks fixed-form bits. Presents the decoded frame to the controller logic over a valid/ready handshake.

Parameters:
FRAME_BITS, 108, width of the received frame vector; bit 0 is SOF, MSB-first.
CRC_POLY, 15'h4599, CAN CRC-15 generator polynomial.
FILTER_CODE, 11'h000, acceptance code; used only with the optional feature.
FILTER_MASK, 11'h000, acceptance mask, 1 = bit compared; used only with the optional feature.

Ports:
i_Clock  in  1  system clock, rising edge
i_Rst_n  in  1  asynchronous active-low reset
i_Rx_DV  in  1  one-cycle strobe: i_Rx_Frame is valid
i_Rx_Frame  in  [0:107]  received frame; layout SOF 0, ID 1-11, RTR 12, IDE 13, r0 14, DLC 15-18, DATA 19-82, CRC 83-97, CRC delimiter 98, ACK 99, ACK delimiter 100, EOF 101-107
i_Frame_Ready  in  1  consumer accepts the decoded frame
o_Frame_Valid  out  1  decoded frame held on outputs
o_Id  out  11  identifier, bit 1 = MSB
o_Rtr  out  1  RTR bit
o_Dlc  out  4  DLC field, raw value
o_Data  out  64  data bytes; frame bit 19 = o_Data[63]
o_Crc_Err  out  1  computed CRC differs from the CRC field
o_Form_Err  out  1  form violation
o_Busy  out  1  decoder not in IDLE
o_Overrun  out  1  one-cycle pulse: i_Rx_DV dropped because the decoder was busy

Behaviour:
- Single clock i_Clock. i_Rst_n is asynchronous, active-low.
- Reset: all outputs 0; state IDLE; CRC register 0; bit index 0.
- States: IDLE, CRC_RUN, CHECK, OUT.
- IDLE: when i_Rx_DV=1, capture i_Rx_Frame into an internal shadow register, clear CRC and index, go to CRC_RUN.
- CRC_RUN: one frame bit per clock, bits 0..82 in order. Per bit b: fb = b ^ crc[14]; crc = {crc[13:0],1'b0} ^ (fb ? CRC_POLY : 0). After bit 82 (83 clocks), go to CHECK.
- CHECK, one clock:
  - o_Crc_Err = (crc != frame[83:97]).
  - o_Form_Err = SOF!=0, or IDE!=0, or CRC delimiter!=1, or ACK delimiter!=1, or any EOF bit!=1, or DLC>8.
  - Register ID, RTR, DLC and DATA to the outputs.
  - Set o_Frame_Valid=1 and go to OUT.
- Latency: o_Frame_Valid is high after the 85th rising edge following the edge that sampled i_Rx_DV. That is 1 capture edge + 83 CRC edges + 1 CHECK edge.
- OUT: outputs stay stable while o_Frame_Valid=1 and i_Frame_Ready=0.
- Handshake completes on a clock where o_Frame_Valid=1 and i_Frame_Ready=1. On that clock: o_Frame_Valid drops next cycle, error flags clear, state goes to IDLE.
- i_Frame_Ready high before valid has no effect. The handshake is never combinational from ready to valid.
- Errored frames are still presented. The consumer decides on discard.
- i_Rx_DV in any state other than IDLE: frame ignored, shadow register untouched, o_Overrun pulses high for exactly one cycle.
- i_Rx_DV on the same clock a handshake completes: dropped, with overrun. IDLE is only reached on the next edge.
- DLC>8: o_Dlc reports the raw value and o_Form_Err=1. All 64 data bits are always output.
- Reset asserted mid-operation: immediate return to the reset state. No partial frame is ever presented.
- o_Busy = (state != IDLE).

Optional Feature:
Macro CAN_DEC_ACCEPT_FILTER_EN.
- Defined: in CHECK, if ((ID ^ FILTER_CODE) & FILTER_MASK) != 0, the frame is rejected. o_Frame_Valid stays 0, flags stay 0, state returns to IDLE. Errors in rejected frames are not reported.
- Not defined: every frame is presented, and FILTER_CODE/FILTER_MASK are unused.

Test Plan:
- Valid frame, ID=11'h123, RTR=0, DLC=8, data 64'h0123456789ABCDEF, CRC field from a reference model, delimiters and EOF all 1 -> o_Frame_Valid rises 85 edges after DV; o_Id=123h, o_Dlc=8, o_Data=0123456789ABCDEF, o_Crc_Err=0, o_Form_Err=0.
- Same frame with bit 50 inverted -> o_Crc_Err=1, o_Form_Err=0, o_Data shows the flipped bit.
- Same frame with EOF bit 104=0, then separately DLC=4'hF -> o_Form_Err=1 in each case, o_Crc_Err=0 for the EOF case.
- Hold i_Frame_Ready=0 for 20 cycles, then assert for 1 cycle -> outputs stable throughout; valid low the cycle after; o_Busy=0.
- Second i_Rx_DV 10 cycles after the first -> o_Overrun single-cycle pulse; first frame decoded unchanged.
- With CAN_DEC_ACCEPT_FILTER_EN, FILTER_CODE=11'h123, FILTER_MASK=11'h7FF: ID 123h presented, ID 124h never raises o_Frame_Valid. Also assert i_Rst_n=0 during CRC_RUN -> all outputs 0 immediately.
